envelope_detector: RTL and testbench

Envelope follower for the synth datapath: the receive-side counterpart of the ADSR envelope generator. It takes a strobed 8-bit signed audio stream and recovers an 8-bit amplitude envelope using programmable attack/release slew rates. It also recovers a gate/trigger signal through threshold hysteresis with a hold timer. Typical uses are sidechain/ducking, auto-trigger of the ADSR from external audio, and envelope measurement in test.

---
 rtl/synth_pkg.sv | 12 +
 rtl/envelope_detector_if.sv | 30 +++
 rtl/env_slew.sv | 39 +++
 rtl/envelope_detector.sv | 78 +++++++
 tb/tb_envelope_detector.sv | 160 ++++++++++++++++
 5 files changed

// File: rtl/synth_pkg.sv
// Shared synth datapath definitions: gate-state encodings and rectifier ceiling.
package synth_pkg;

  typedef enum logic [1:0] {
    GATE_OFF  = 2'd0,
    GATE_ON   = 2'd1,
    GATE_HOLD = 2'd2
  } gate_state_t;

  localparam logic [7:0] MAG_MAX = 8'd254;

endpackage

// File: rtl/envelope_detector_if.sv
// Sample-in / envelope-out bundle for the envelope detector, plus gate-state debug view.
interface envelope_detector_if;
  import synth_pkg::*;

  // sample_valid is a one-cycle strobe with no ready: a high sample_valid at a rising
  // edge (outside reset) is always consumed; env_valid strobes one cycle later with the
  // updated envelope/gate. All config fields are only looked at while sample_valid is high.
  logic        sample_valid;
  logic [7:0]  sample;
  logic [7:0]  ai;
  logic [7:0]  ri;
  logic [7:0]  thr_on;
  logic [7:0]  thr_off;
  logic [7:0]  hold;
  logic [7:0]  envelope;
  logic        gate;
  logic        env_valid;
  gate_state_t state;

  modport master (
    output sample_valid, sample, ai, ri, thr_on, thr_off, hold,
    input  envelope, gate, env_valid, state
  );

  modport slave (
    input  sample_valid, sample, ai, ri, thr_on, thr_off, hold,
    output envelope, gate, env_valid, state
  );

endinterface

// File: rtl/env_slew.sv
// Combinational full-wave rectifier and saturating attack/release slew limiter.
module env_slew
  import synth_pkg::*;
(
  input  logic [7:0] i_sample,
  input  logic [7:0] i_envelope,
  input  logic [7:0] i_ai,
  input  logic [7:0] i_ri,
  output logic [7:0] o_env_next
);

  logic [6:0]        w_abs;
  logic [7:0]        w_mag;
  logic [8:0]        w_sum;
  logic signed [8:0] w_diff;

  // -128 has no positive counterpart in 8 bits, so it saturates to 127.
  always_comb begin
    if (i_sample == 8'h80)
      w_abs = 7'd127;
    else if (i_sample[7])
      w_abs = 7'(~i_sample[6:0] + 7'd1);
    else
      w_abs = i_sample[6:0];
  end

  assign w_mag  = {w_abs, 1'b0};
  assign w_sum  = {1'b0, i_envelope} + {1'b0, i_ai};
  assign w_diff = $signed({1'b0, i_envelope}) - $signed({1'b0, i_ri});

  always_comb begin
    o_env_next = i_envelope;
    if (w_mag > i_envelope)
      o_env_next = (w_sum > {1'b0, w_mag}) ? w_mag : w_sum[7:0];
    else if (w_mag < i_envelope)
      o_env_next = (w_diff < $signed({1'b0, w_mag})) ? w_mag : w_diff[7:0];
  end

endmodule

// File: rtl/envelope_detector.sv
// Envelope follower with hysteretic gate recovery and hold timer; all state moves on sample strobes.
module envelope_detector
  import synth_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  envelope_detector_if.slave  bus
);

  logic [7:0]  r_env;
  logic        r_valid;
  gate_state_t r_state;
  logic [7:0]  r_cnt;

  logic [7:0]  w_env_next;
  gate_state_t w_state_next;
  logic [7:0]  w_cnt_next;

  env_slew u_slew (
    .i_sample   (bus.sample),
    .i_envelope (r_env),
    .i_ai       (bus.ai),
    .i_ri       (bus.ri),
    .o_env_next (w_env_next)
  );

  // Thresholds are judged against the envelope being written this strobe.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    case (r_state)
      GATE_OFF: begin
        if (w_env_next >= bus.thr_on) w_state_next = GATE_ON;
      end
      GATE_ON: begin
        if (w_env_next < bus.thr_off) begin
          if (bus.hold != 8'd0) begin
            w_state_next = GATE_HOLD;
            w_cnt_next   = bus.hold - 8'd1;
          end else begin
            w_state_next = GATE_OFF;
          end
        end
      end
      GATE_HOLD: begin
        if (w_env_next >= bus.thr_on)
          w_state_next = GATE_ON;
        else if (r_cnt == 8'd0)
          w_state_next = GATE_OFF;
        else
          w_cnt_next = r_cnt - 8'd1;
      end
      default: w_state_next = GATE_OFF;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_env   <= 8'd0;
      r_valid <= 1'b0;
      r_state <= GATE_OFF;
      r_cnt   <= 8'd0;
    end else begin
      r_valid <= bus.sample_valid;
      if (bus.sample_valid) begin
        r_env   <= w_env_next;
        r_state <= w_state_next;
        r_cnt   <= w_cnt_next;
      end
    end
  end

  assign bus.envelope  = r_env;
  assign bus.env_valid = r_valid;
  assign bus.gate      = (r_state != GATE_OFF);
  assign bus.state     = r_state;

endmodule

// File: tb/tb_envelope_detector.sv
// Directed bench for envelope_detector: reset, attack, rectify corners, gapped release, gate hold/retrigger.
module tb_envelope_detector;
  import synth_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;

  envelope_detector_if bus ();

  envelope_detector dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One strobe, then sample outputs 1 time unit after the capturing edge.
  task automatic strobe(input logic [7:0] s);
    @(negedge clk);
    bus.sample_valid = 1'b1;
    bus.sample       = s;
    @(posedge clk);
    #1;
    bus.sample_valid = 1'b0;
  endtask

  task automatic idle();
    @(negedge clk);
    bus.sample_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.sample_valid = 1'b0;
    bus.sample  = 8'd0;
    bus.ai      = 8'd255;
    bus.ri      = 8'd255;
    bus.thr_on  = 8'd255;
    bus.thr_off = 8'd0;
    bus.hold    = 8'd0;

    // Reset with strobes pulsing: they must be discarded.
    rst = 1'b0;
    strobe(8'd100);
    strobe(8'd100);
    chk("rst_env", bus.envelope, 8'd0);
    chk("rst_gate", {7'd0, bus.gate}, 8'd0);
    chk("rst_valid", {7'd0, bus.env_valid}, 8'd0);
    chk("rst_state", {6'd0, bus.state}, {6'd0, GATE_OFF});

    @(negedge clk);
    rst = 1'b1;
    idle();
    chk("idle_valid", {7'd0, bus.env_valid}, 8'd0);

    // Attack: 16 per sample toward mag 200.
    bus.ai = 8'd16;
    for (int k = 1; k <= 13; k++) begin
      strobe(8'd100);
      chk("attack_env", bus.envelope, (k == 13) ? 8'd200 : 8'(16 * k));
      if (k == 1) chk("attack_first_valid", {7'd0, bus.env_valid}, 8'd1);
    end
    strobe(8'd100);
    chk("attack_settled", bus.envelope, 8'd200);
    chk("attack_gate_off", {7'd0, bus.gate}, 8'd0);
    idle();
    chk("valid_drops", {7'd0, bus.env_valid}, 8'd0);

    // Rectifier corners.
    bus.ai = 8'd255;
    bus.ri = 8'd255;
    strobe(8'h80);
    chk("rect_m128", bus.envelope, MAG_MAX);
    strobe(8'hFF);
    chk("rect_m1", bus.envelope, 8'd2);
    strobe(8'h00);
    chk("rect_zero", bus.envelope, 8'd0);

    // Release with strobes on every third cycle.
    strobe(8'd100);
    chk("rel_start", bus.envelope, 8'd200);
    bus.ri = 8'd50;
    for (int k = 1; k <= 5; k++) begin
      strobe(8'd0);
      chk("rel_env", bus.envelope, (k >= 4) ? 8'd0 : 8'(200 - 50 * k));
      chk("rel_valid", {7'd0, bus.env_valid}, 8'd1);
      bus.ri = 8'd200;  // between strobes: must have no effect
      idle();
      chk("rel_gap_env", bus.envelope, (k >= 4) ? 8'd0 : 8'(200 - 50 * k));
      chk("rel_gap_valid", {7'd0, bus.env_valid}, 8'd0);
      idle();
      bus.ri = 8'd50;
    end

    // Gate hysteresis with hold=3.
    bus.ai = 8'd255; bus.ri = 8'd255;
    bus.thr_on = 8'd128; bus.thr_off = 8'd64; bus.hold = 8'd3;
    strobe(8'd100);
    chk("gate_on", {7'd0, bus.gate}, 8'd1);
    chk("gate_on_state", {6'd0, bus.state}, {6'd0, GATE_ON});
    for (int k = 1; k <= 4; k++) begin
      strobe(8'd0);
      chk("hold_gate", {7'd0, bus.gate}, (k <= 3) ? 8'd1 : 8'd0);
    end
    chk("hold_end_state", {6'd0, bus.state}, {6'd0, GATE_OFF});

    // hold=0 drops on the first quiet sample.
    bus.hold = 8'd0;
    strobe(8'd100);
    chk("h0_gate_on", {7'd0, bus.gate}, 8'd1);
    strobe(8'd0);
    chk("h0_gate_off", {7'd0, bus.gate}, 8'd0);

    // Retrigger from HOLD restarts the full hold.
    bus.hold = 8'd3;
    strobe(8'd100);
    strobe(8'd0);
    chk("rt_in_hold", {6'd0, bus.state}, {6'd0, GATE_HOLD});
    strobe(8'd100);
    chk("rt_state_on", {6'd0, bus.state}, {6'd0, GATE_ON});
    chk("rt_gate", {7'd0, bus.gate}, 8'd1);
    for (int k = 1; k <= 4; k++) begin
      strobe(8'd0);
      chk("rt_hold_gate", {7'd0, bus.gate}, (k <= 3) ? 8'd1 : 8'd0);
    end

    // Reset in the middle of HOLD.
    strobe(8'd100);
    strobe(8'd0);
    chk("mid_hold", {7'd0, bus.gate}, 8'd1);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("midrst_gate", {7'd0, bus.gate}, 8'd0);
    chk("midrst_env", bus.envelope, 8'd0);
    chk("midrst_state", {6'd0, bus.state}, {6'd0, GATE_OFF});
    @(negedge clk);
    rst = 1'b1;
    strobe(8'd0);
    chk("post_rst_env", bus.envelope, 8'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
